// File: rtl/vbs_pkg.sv
// Shared definitions for the variable-block-size best-MV selector:
// partition index map, FSM encoding and SAD array type.
package vbs_pkg;

    localparam int NUM_PART   = 41;

    // Partition index map: 4x4 blocks are row-major, larger shapes follow.
    localparam int P4x4_BASE  = 0;
    localparam int P4x8_BASE  = 16;
    localparam int P8x4_BASE  = 24;
    localparam int P8x8_BASE  = 32;
    localparam int P16x8_BASE = 36;
    localparam int P8x16_BASE = 38;
    localparam int P16x16     = 40;

    localparam int SAD_W_DEF  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    typedef logic [NUM_PART-1:0][SAD_W_DEF-1:0] sad_arr_t;

endpackage

// File: rtl/vbs_min_cell.sv
// One partition's compare-and-hold register: keeps the smallest SAD seen
// in the current search and the motion vector that produced it.
module vbs_min_cell
    import vbs_pkg::*;
#(
    parameter int SAD_WIDTH = 16,
    parameter int MV_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_init,
    input  logic                 i_en,
    input  logic [SAD_WIDTH-1:0] i_sad,
    input  logic [MV_WIDTH-1:0]  i_mvx,
    input  logic [MV_WIDTH-1:0]  i_mvy,
    output logic [SAD_WIDTH-1:0] o_best_sad,
    output logic [MV_WIDTH-1:0]  o_best_mvx,
    output logic [MV_WIDTH-1:0]  o_best_mvy
);

    logic [SAD_WIDTH-1:0] r_sad;
    logic [MV_WIDTH-1:0]  r_mvx;
    logic [MV_WIDTH-1:0]  r_mvy;

    // Running minimum; strict compare so a tie keeps the earlier position
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sad <= {SAD_WIDTH{1'b1}};
            r_mvx <= {MV_WIDTH{1'b0}};
            r_mvy <= {MV_WIDTH{1'b0}};
        end else if (i_init) begin
            r_sad <= {SAD_WIDTH{1'b1}};
            r_mvx <= {MV_WIDTH{1'b0}};
            r_mvy <= {MV_WIDTH{1'b0}};
        end else if (i_en && (i_sad < r_sad)) begin
            r_sad <= i_sad;
            r_mvx <= i_mvx;
            r_mvy <= i_mvy;
        end
    end

    assign o_best_sad = r_sad;
    assign o_best_mvx = r_mvx;
    assign o_best_mvy = r_mvy;

endmodule

// File: rtl/vbs_best_mv_select.sv
// Tracks per-partition minimum SAD and its MV over a raster-scanned search
// window; FSM and MV position counters live here, minima in vbs_min_cell.
module vbs_best_mv_select
    import vbs_pkg::*;
#(
    parameter int SAD_WIDTH    = 16,
    parameter int SEARCH_RANGE = 16,
    parameter int MV_WIDTH     = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               sad_valid,
    input  logic [NUM_PART-1:0][SAD_WIDTH-1:0] sad_in,
    output logic                               busy,
    output logic                               done,
    output logic [NUM_PART-1:0][SAD_WIDTH-1:0] best_sad,
    output logic [NUM_PART-1:0][MV_WIDTH-1:0]  best_mvx,
    output logic [NUM_PART-1:0][MV_WIDTH-1:0]  best_mvy
);

    localparam logic signed [MV_WIDTH-1:0] MV_MIN = MV_WIDTH'(-SEARCH_RANGE);
    localparam logic signed [MV_WIDTH-1:0] MV_MAX = MV_WIDTH'(SEARCH_RANGE - 1);
    localparam logic signed [MV_WIDTH-1:0] MV_ONE = MV_WIDTH'(1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic signed [MV_WIDTH-1:0] r_mvx;
    logic signed [MV_WIDTH-1:0] r_mvy;
    logic                       r_busy;
    logic                       r_done;
    logic                       w_init;
    logic                       w_accept;
    logic                       w_last;

    // A start in any state reinitialises; a sample arriving with start is dropped.
    assign w_init   = start;
    assign w_accept = (r_state == ST_SEARCH) && sad_valid && !start;
    assign w_last   = w_accept && (r_mvx == MV_MAX) && (r_mvy == MV_MAX);

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SEARCH: begin
                if (start) begin
                    w_state_nxt = ST_SEARCH;
                end else if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SEARCH;
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SEARCH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with busy/done registered from the next state
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == ST_SEARCH);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Raster position counters; x wraps into a y increment
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mvx <= MV_MIN;
            r_mvy <= MV_MIN;
        end else if (w_init) begin
            r_mvx <= MV_MIN;
            r_mvy <= MV_MIN;
        end else if (w_accept) begin
            if (r_mvx == MV_MAX) begin
                r_mvx <= MV_MIN;
                r_mvy <= (r_mvy == MV_MAX) ? MV_MIN : (r_mvy + MV_ONE);
            end else begin
                r_mvx <= r_mvx + MV_ONE;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PART; gi++) begin : g_cell
        vbs_min_cell #(
            .SAD_WIDTH (SAD_WIDTH),
            .MV_WIDTH  (MV_WIDTH)
        ) u_cell (
            .clk        (clk),
            .rst        (rst),
            .i_init     (w_init),
            .i_en       (w_accept),
            .i_sad      (sad_in[gi]),
            .i_mvx      (r_mvx),
            .i_mvy      (r_mvy),
            .o_best_sad (best_sad[gi]),
            .o_best_mvx (best_mvx[gi]),
            .o_best_mvy (best_mvy[gi])
        );
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_vbs_best_mv_select.sv
// Bench for vbs_best_mv_select with SEARCH_RANGE=2: directed scenarios plus
// random traffic, checked each cycle against a position-count model.
module tb_vbs_best_mv_select;

    localparam int NP  = 41;
    localparam int SW  = 16;
    localparam int MW  = 6;
    localparam int SR  = 2;
    localparam int NPOS = (2 * SR) * (2 * SR);
    localparam int CW  = NP * SW;

    logic                    clk;
    logic                    rst;
    logic                    start;
    logic                    sad_valid;
    logic [NP-1:0][SW-1:0]   sad_in;
    logic                    busy;
    logic                    done;
    logic [NP-1:0][SW-1:0]   best_sad;
    logic [NP-1:0][MW-1:0]   best_mvx;
    logic [NP-1:0][MW-1:0]   best_mvy;

    vbs_best_mv_select #(
        .SAD_WIDTH    (SW),
        .SEARCH_RANGE (SR),
        .MV_WIDTH     (MW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sad_valid (sad_valid),
        .sad_in    (sad_in),
        .busy      (busy),
        .done      (done),
        .best_sad  (best_sad),
        .best_mvx  (best_mvx),
        .best_mvy  (best_mvy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: expected outputs derived from a sample count within the window
    logic                    m_busy;
    logic                    m_done;
    int                      m_pos;
    logic [NP-1:0][SW-1:0]   m_sad;
    logic [NP-1:0][MW-1:0]   m_mvx;
    logic [NP-1:0][MW-1:0]   m_mvy;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt = 0;
    logic chk_en = 1'b0;
    logic [NP-1:0][SW-1:0]   nsad;

    function automatic logic [MW-1:0] pos_x(input int pos);
        return MW'((pos % (2 * SR)) - SR);
    endfunction

    function automatic logic [MW-1:0] pos_y(input int pos);
        return MW'((pos / (2 * SR)) - SR);
    endfunction

    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_pos  <= 0;
            for (int p = 0; p < NP; p++) begin
                m_sad[p] <= 16'hFFFF;
                m_mvx[p] <= 6'd0;
                m_mvy[p] <= 6'd0;
            end
        end else if (start) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            m_pos  <= 0;
            for (int p = 0; p < NP; p++) begin
                m_sad[p] <= 16'hFFFF;
                m_mvx[p] <= 6'd0;
                m_mvy[p] <= 6'd0;
            end
        end else if (m_busy && sad_valid) begin
            for (int p = 0; p < NP; p++) begin
                if (sad_in[p] < m_sad[p]) begin
                    m_sad[p] <= sad_in[p];
                    m_mvx[p] <= pos_x(m_pos);
                    m_mvy[p] <= pos_y(m_pos);
                end
            end
            m_pos  <= m_pos + 1;
            m_done <= (m_pos == NPOS - 1);
            m_busy <= (m_pos != NPOS - 1);
        end else begin
            m_done <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", CW'(busy), CW'(m_busy));
            chk("done", CW'(done), CW'(m_done));
            chk("best_sad", CW'(best_sad), CW'(m_sad));
            chk("best_mvx", CW'(best_mvx), CW'(m_mvx));
            chk("best_mvy", CW'(best_mvy), CW'(m_mvy));
            if (done === 1'b1) done_cnt++;
        end
    end

    task automatic step(input logic r, input logic st, input logic v);
        @(negedge clk);
        rst       = r;
        start     = st;
        sad_valid = v;
        sad_in    = nsad;
    endtask

    task automatic fill_const(input int val);
        for (int p = 0; p < NP; p++) nsad[p] = SW'(val);
    endtask

    task automatic fill_rand(input int hi);
        for (int p = 0; p < NP; p++) nsad[p] = SW'($urandom_range(0, hi));
    endtask

    logic [NP-1:0][SW-1:0] all_ff;
    logic [NP-1:0][SW-1:0] all_85;
    logic [NP-1:0][MW-1:0] all_one;

    initial begin
        rst = 1'b0; start = 1'b0; sad_valid = 1'b0; sad_in = '0; nsad = '0;
        for (int p = 0; p < NP; p++) begin
            all_ff[p]  = 16'hFFFF;
            all_85[p]  = 16'd85;
            all_one[p] = 6'd1;
        end

        // Reset then idle
        step(1'b0, 1'b0, 1'b0);
        chk_en = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        chk("rst_busy", CW'(busy), CW'(1'b0));
        chk("rst_done", CW'(done), CW'(1'b0));
        chk("rst_sad", CW'(best_sad), CW'(all_ff));
        chk("rst_mvx", CW'(best_mvx), CW'(0));
        for (int i = 0; i < 4; i++) begin
            fill_rand(100);
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("idle_sad", CW'(best_sad), CW'(all_ff));
        chk("idle_busy", CW'(busy), CW'(1'b0));

        // Ramp, back-to-back
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NPOS; i++) begin
            fill_const(100 - i);
            step(1'b1, 1'b0, 1'b1);
        end
        fill_const(0);
        step(1'b1, 1'b0, 1'b0);
        chk("ramp_done", CW'(done), CW'(1'b1));
        chk("ramp_busy", CW'(busy), CW'(1'b0));
        chk("ramp_sad", CW'(best_sad), CW'(all_85));
        chk("ramp_mvx", CW'(best_mvx), CW'(all_one));
        chk("ramp_mvy", CW'(best_mvy), CW'(all_one));

        // Per-partition minima, started during the DONE cycle
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NPOS; i++) begin
            for (int p = 0; p < NP; p++) nsad[p] = ((p % NPOS) == i) ? 16'd10 : 16'd500;
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("pp_done", CW'(done), CW'(1'b1));
        chk("pp40_sad", CW'(best_sad[40]), CW'(16'd10));
        chk("pp40_mvx", CW'(best_mvx[40]), CW'(6'h3E));
        chk("pp40_mvy", CW'(best_mvy[40]), CW'(6'd0));
        chk("pp5_mvx", CW'(best_mvx[5]), CW'(6'h3F));
        chk("pp5_mvy", CW'(best_mvy[5]), CW'(6'h3F));

        // Tie keeps the earlier position
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NPOS; i++) begin
            fill_const((i == 3 || i == 9) ? 50 : 200);
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0);
        chk("tie_sad", CW'(best_sad[0]), CW'(16'd50));
        chk("tie_mvx", CW'(best_mvx[0]), CW'(6'd1));
        chk("tie_mvy", CW'(best_mvy[0]), CW'(6'h3E));

        // Restart mid-search; the sample arriving with the restart is dropped
        step(1'b1, 1'b0, 1'b0);
        done_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            fill_rand(30);
            step(1'b1, 1'b0, 1'b1);
        end
        fill_const(0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < NPOS; i++) begin
            fill_const((i == 0) ? 20 : 300);
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("rs_sad", CW'(best_sad[7]), CW'(16'd20));
        chk("rs_mvx", CW'(best_mvx[7]), CW'(6'h3E));
        chk("rs_mvy", CW'(best_mvy[7]), CW'(6'h3E));
        chk("rs_done_cnt", CW'(done_cnt), CW'(1));

        // Gapped valid gives the ramp result
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < NPOS; i++) begin
            fill_const(100 - i);
            step(1'b1, 1'b0, 1'b1);
            fill_rand(20);
            step(1'b1, 1'b0, 1'b0);
        end
        chk("gap_done", CW'(done), CW'(1'b1));
        chk("gap_sad", CW'(best_sad), CW'(all_85));
        chk("gap_mvy", CW'(best_mvy), CW'(all_one));

        // Reset at sample 5 abandons the search
        step(1'b1, 1'b0, 1'b0);
        done_cnt = 0;
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            fill_rand(50);
            step(1'b1, 1'b0, 1'b1);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("mrst_busy", CW'(busy), CW'(1'b0));
        chk("mrst_sad", CW'(best_sad), CW'(all_ff));
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        chk("mrst_no_done", CW'(done_cnt), CW'(0));

        // Random traffic: gaps, restarts, rare resets, small SADs for ties
        for (int c = 0; c < 3000; c++) begin
            fill_rand(63);
            step(($urandom_range(0, 699) != 0),
                 ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 9) < 7));
        end
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
